// File: rtl/led_sweep_ctrl.sv
// LED bar sequencer: fill/drain, running dot, bouncing dot and blink-all patterns
// with start/stop/pause control. Define LED_SWEEP_DIR_EN to add the dir (bit-reverse) input.
module led_sweep_ctrl #(
    parameter int PRESCALE = 1_000_000,
    parameter int DIV_W    = 28,
    parameter int REPEAT   = 2
) (
    input  logic       CLK,
    input  logic       nrst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [2:0] speed_sel,
`ifdef LED_SWEEP_DIR_EN
    input  logic       dir,
`endif
    output logic [7:0] O,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [2:0]        spd_q, spd_d;
    logic [3:0]        step_q, step_d;
    logic [7:0]        cycle_q, cycle_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [7:0]        o_q, o_d;
`ifdef LED_SWEEP_DIR_EN
    logic              dir_q, dir_d;
`endif

    logic [DIV_W-1:0]  term;
    logic              tick;
    logic [3:0]        last;
    logic [3:0]        step_adv;
    logic [7:0]        pat_start, pat_run;

    function automatic logic [3:0] last_step(input logic [1:0] m);
        case (m)
            2'd0:    return 4'd15;
            2'd1:    return 4'd7;
            2'd2:    return 4'd13;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [7:0] pattern(input logic [1:0] m, input logic [3:0] s);
        logic [4:0] n;
        logic [3:0] pos;
        logic [7:0] pat;
        pat = 8'h00;
        n   = 5'd0;
        pos = 4'd0;
        case (m)
            2'd0: begin
                // lit count rises 1..8 then falls 8..1; bits fill from O[7] downward
                n   = (s < 4'd8) ? ({1'b0, s} + 5'd1) : (5'd16 - {1'b0, s});
                pat = 8'hFF << (5'd8 - n);
            end
            2'd1: pat = 8'h80 >> s;
            2'd2: begin
                pos = (s < 4'd8) ? s : (4'd14 - s);
                pat = 8'h80 >> pos;
            end
            default: pat = (s == 4'd0) ? 8'hFF : 8'h00;
        endcase
        return pat;
    endfunction

`ifdef LED_SWEEP_DIR_EN
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction
`endif

    assign term     = (DIV_W'(PRESCALE) << spd_q) - DIV_W'(1);
    assign tick     = (presc_q == term);
    assign last     = last_step(mode_q);
    assign step_adv = (step_q == last) ? 4'd0 : (step_q + 4'd1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pat_start = pattern(mode, 4'd0);
        pat_run   = pattern(mode_q, step_adv);
`ifdef LED_SWEEP_DIR_EN
        if (dir)   pat_start = rev8(pat_start);
        if (dir_q) pat_run   = rev8(pat_run);
`endif
    end

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        spd_d   = spd_q;
        step_d  = step_q;
        cycle_d = cycle_q;
        presc_d = presc_q;
        o_d     = o_q;
`ifdef LED_SWEEP_DIR_EN
        dir_d   = dir_q;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    mode_d  = mode;
                    spd_d   = speed_sel;
`ifdef LED_SWEEP_DIR_EN
                    dir_d   = dir;
`endif
                    step_d  = 4'd0;
                    cycle_d = 8'd0;
                    presc_d = '0;
                    o_d     = pat_start;
                end
            end
            RUN: begin
                // stop beats pause, pause beats the step tick
                if (stop) begin
                    state_d = IDLE;
                    o_d     = 8'h00;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    step_d  = step_adv;
                    o_d     = pat_run;
                    if (step_q == last) begin
                        if (REPEAT != 0 && (cycle_q + 8'd1) == 8'(REPEAT)) begin
                            state_d = DONE;
                            o_d     = 8'h00;
                        end else if (REPEAT != 0) begin
                            cycle_d = cycle_q + 8'd1;
                        end
                    end
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    o_d     = 8'h00;
                end else if (pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                o_d     = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            mode_q  <= 2'd0;
            spd_q   <= 3'd0;
            step_q  <= 4'd0;
            cycle_q <= 8'd0;
            presc_q <= '0;
            o_q     <= 8'h00;
`ifdef LED_SWEEP_DIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state   <= state_d;
            mode_q  <= mode_d;
            spd_q   <= spd_d;
            step_q  <= step_d;
            cycle_q <= cycle_d;
            presc_q <= presc_d;
            o_q     <= o_d;
`ifdef LED_SWEEP_DIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign O    = o_q;
    assign busy = (state == RUN) || (state == PAUSE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Self-checking bench for led_sweep_ctrl: table-driven pattern runs with a queue scoreboard,
// plus hand-written pause, stop, infinite-repeat and async-reset sequences.
module tb_led_sweep_ctrl;

    logic       CLK = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] speed_sel = 3'd0;
    logic       dir = 1'b0;
    logic [7:0] O, O_inf;
    logic       busy, done, busy_inf, done_inf;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    led_sweep_ctrl #(.PRESCALE(4), .DIV_W(28), .REPEAT(2)) dut (
        .CLK(CLK), .nrst(nrst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .speed_sel(speed_sel),
`ifdef LED_SWEEP_DIR_EN
        .dir(dir),
`endif
        .O(O), .busy(busy), .done(done)
    );

    led_sweep_ctrl #(.PRESCALE(4), .DIV_W(28), .REPEAT(0)) dut_inf (
        .CLK(CLK), .nrst(nrst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .speed_sel(speed_sel),
`ifdef LED_SWEEP_DIR_EN
        .dir(dir),
`endif
        .O(O_inf), .busy(busy_inf), .done(done_inf)
    );

    typedef struct packed {
        logic [1:0]         mode;
        logic [2:0]         spd;
        logic [4:0]         nsteps;
        logic [0:15][7:0]   exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push the whole expected step sequence (two repeats), then pop one entry per step period.
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] q[$];
        int per;
        per = 4 << v.spd;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < int'(v.nsteps); s++) q.push_back(v.exp[s]);
        mode = v.mode;
        speed_sel = v.spd;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        while (q.size() > 0) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            for (int j = 0; j < per; j++) begin
                check({tag, " O"}, 32'(O), 32'(q[0]));
                @(negedge CLK);
            end
            void'(q.pop_front());
        end
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " done O"}, 32'(O), 32'd0);
        check({tag, " done busy"}, 32'(busy), 32'd0);
        @(negedge CLK);
        check({tag, " done single"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{mode: 2'd1, spd: 3'd0, nsteps: 5'd8,
                    exp: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 64'h0}};
        vecs[1] = '{mode: 2'd0, spd: 3'd1, nsteps: 5'd16,
                    exp: {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                          8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80}};
        vecs[2] = '{mode: 2'd2, spd: 3'd0, nsteps: 5'd14,
                    exp: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                          8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 16'h0}};
        vecs[3] = '{mode: 2'd3, spd: 3'd0, nsteps: 5'd2,
                    exp: {8'hFF, 8'h00, 112'h0}};

        // reset state
        repeat (3) @(negedge CLK);
        check("reset O", 32'(O), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        nrst = 1'b1;
        @(negedge CLK);
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef LED_SWEEP_DIR_EN
        begin
            vec_t vd;
            vd = '{mode: 2'd1, spd: 3'd0, nsteps: 5'd8,
                   exp: {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 64'h0}};
            dir = 1'b1;
            run_vec(vd, "dir dot");
            dir = 1'b0;
        end
`endif

        // pause in bounce at step 3, hold, resume from the frozen prescaler
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        mode = 2'd2;
        speed_sel = 3'd0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (13) @(negedge CLK);
        check("pause pre O", 32'(O), 32'h10);
        pause = 1'b1;
        @(negedge CLK);
        pause = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("pause hold O", 32'(O), 32'h10);
            if (k == 0 || k == 19) check("pause busy", 32'(busy), 32'd1);
            @(negedge CLK);
        end
        pause = 1'b1;
        @(negedge CLK);
        pause = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("resume remain O", 32'(O), 32'h10);
            @(negedge CLK);
        end
        check("resume step O", 32'(O), 32'h08);
        begin
            logic [7:0] sb[$];
            sb.push_back(8'h04);
            sb.push_back(8'h02);
            sb.push_back(8'h01);
            sb.push_back(8'h02);
            while (sb.size() > 0) begin
                repeat (4) @(negedge CLK);
                check("bounce after pause O", 32'(O), 32'(sb.pop_front()));
            end
        end
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        check("stop pause O", 32'(O), 32'd0);
        check("stop pause busy", 32'(busy), 32'd0);
        check("stop no done", 32'(done), 32'd0);

        // pause coinciding with the tick: step must not advance
        mode = 2'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        check("ptick pre O", 32'(O), 32'h80);
        pause = 1'b1;
        @(negedge CLK);
        pause = 1'b0;
        check("ptick held O", 32'(O), 32'h80);
        check("ptick busy", 32'(busy), 32'd1);
        @(negedge CLK);
        check("ptick paused O", 32'(O), 32'h80);
        pause = 1'b1;
        @(negedge CLK);
        pause = 1'b0;
        check("ptick resume O", 32'(O), 32'h80);
        @(negedge CLK);
        check("ptick advance O", 32'(O), 32'h40);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;

        // start with stop in IDLE stays IDLE
        start = 1'b1;
        stop = 1'b1;
        @(negedge CLK);
        check("start+stop busy", 32'(busy), 32'd0);
        check("start+stop O", 32'(O), 32'd0);
        start = 1'b0;
        stop = 1'b0;
        @(negedge CLK);
        check("start+stop after busy", 32'(busy), 32'd0);

        // blink with REPEAT=0 runs until stop
        check("inf idle busy", 32'(busy_inf), 32'd0);
        mode = 2'd3;
        speed_sel = 3'd0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("inf done", 32'(done_inf), 32'd0);
            for (int j = 0; j < 4; j++) begin
                check("inf O", 32'(O_inf), (k % 2 == 0) ? 32'hFF : 32'h00);
                @(negedge CLK);
            end
        end
        check("inf busy", 32'(busy_inf), 32'd1);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        check("inf stop O", 32'(O_inf), 32'd0);
        check("inf stop busy", 32'(busy_inf), 32'd0);

        // async reset between edges mid-run
        mode = 2'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) @(negedge CLK);
        check("prereset busy", 32'(busy), 32'd1);
        check("prereset O", 32'(O), 32'h40);
        @(posedge CLK);
        #2 nrst = 1'b0;
        #1;
        check("async rst O", 32'(O), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst inf O", 32'(O_inf), 32'd0);
        check("async rst inf busy", 32'(busy_inf), 32'd0);
        @(negedge CLK);
        nrst = 1'b1;
        @(negedge CLK);
        check("post rst busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
